// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority-encoder arbiter family.
package prio_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Widest request vector any arbiter in the family supports.
   localparam int unsigned MAX_N = 64;

   // One-hot of idx within an n-bit field; all zero when idx is out of range.
   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
      logic [MAX_N-1:0] v;
      v = '0;
      if (idx < n) begin
         v = MAX_N'(1) << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: highest index (fixed) or first set bit at or
// after ptr, wrapping modulo N (round-robin).
module prio_pick
   import prio_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic          found,
   output logic [IW-1:0] w
);

   // Search by circular distance from ptr so the wrap is modulo N, not 2^IW.
   always_comb begin
      int unsigned p;
      int unsigned d;
      int unsigned best;
      p     = 32'(ptr);
      d     = 0;
      best  = N;
      found = |req;
      w     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) begin
            if (mode == MODE_FIXED) begin
               w = IW'(i);
            end else begin
               d = (i >= p) ? (i - p) : (i + N - p);
               if (d < best) begin
                  best = d;
                  w    = IW'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered N-input priority arbiter with valid/ack handshake and selectable
// fixed or round-robin priority.
module prio_enc_arb
   import prio_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          mode,
   input  logic          ack,
   output logic          valid,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  grant
);

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            mode_q, mode_d;
   logic            valid_q, valid_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N-1:0]    grant_q, grant_d;
   logic            found;
   logic [IW-1:0]   w;
   logic [MAX_N-1:0] oh_w;

   prio_pick #(
      .N (N)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .mode  (mode),
      .found (found),
      .w     (w)
   );

   assign oh_w = onehot(32'(w), N);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant on any request, release on ack or on withdrawal.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = GRANT;
         GRANT:   if (ack || !req[idx_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/pointer next values; ack beats withdrawal on the same edge.
   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               valid_d = 1'b1;
               idx_d   = w;
               grant_d = oh_w[N-1:0];
               mode_d  = mode;
            end else begin
               valid_d = 1'b0;
               grant_d = '0;
            end
         end
         GRANT: begin
            if (ack) begin
               valid_d = 1'b0;
               grant_d = '0;
               // Mode latched at grant time decides whether the pointer advances.
               if (mode_q == MODE_RR) begin
                  ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
               end
            end else if (!req[idx_q]) begin
               valid_d = 1'b0;
               grant_d = '0;
            end
         end
         default: begin
            valid_d = 1'b0;
            grant_d = '0;
         end
      endcase
   end

   // Output, pointer and latched-mode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         mode_q  <= MODE_FIXED;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
      end
   end

   assign valid = valid_q;
   assign idx   = idx_q;
   assign grant = grant_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Self-checking bench for prio_enc_arb: an 8-input and a 5-input instance
// compared every cycle against a transaction-level reference model.
module tb_prio_enc_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req8;
   logic       mode8, ack8;
   logic       valid8;
   logic [2:0] idx8;
   logic [7:0] grant8;
   logic [4:0] req5;
   logic       mode5, ack5;
   logic       valid5;
   logic [2:0] idx5;
   logic [4:0] grant5;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit v;
      int idx;
      int ptr;
      bit md;
   } mstate_t;

   mstate_t m8, m5;

   always #5 clk = ~clk;

   prio_enc_arb #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req8),
      .mode  (mode8),
      .ack   (ack8),
      .valid (valid8),
      .idx   (idx8),
      .grant (grant8)
   );

   prio_enc_arb #(.N(5)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req5),
      .mode  (mode5),
      .ack   (ack5),
      .valid (valid5),
      .idx   (idx5),
      .grant (grant5)
   );

   function automatic mstate_t mreset();
      mstate_t s;
      s.v = 0; s.idx = 0; s.ptr = 0; s.md = 0;
      return s;
   endfunction

   // One clock edge of the arbiter as a transaction model.
   function automatic mstate_t mstep(mstate_t s, logic [63:0] r, bit md, bit a, int n);
      mstate_t t;
      int w;
      t = s;
      w = -1;
      if (!s.v) begin
         if (md == 1'b0) begin
            for (int i = n - 1; i >= 0; i--) if (w < 0 && r[i]) w = i;
         end else begin
            for (int k = 0; k < n; k++) if (w < 0 && r[(s.ptr + k) % n]) w = (s.ptr + k) % n;
         end
         if (w >= 0) begin
            t.v = 1; t.idx = w; t.md = md;
         end
      end else if (a) begin
         t.v = 0;
         if (s.md) t.ptr = (s.idx + 1) % n;
      end else if (!r[s.idx]) begin
         t.v = 0;
      end
      return t;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("valid8", 64'(valid8), 64'(m8.v));
      chk("idx8",   64'(idx8),   64'(m8.idx));
      chk("grant8", 64'(grant8), m8.v ? (64'd1 << m8.idx) : 64'd0);
      chk("valid5", 64'(valid5), 64'(m5.v));
      chk("idx5",   64'(idx5),   64'(m5.idx));
      chk("grant5", 64'(grant5), m5.v ? (64'd1 << m5.idx) : 64'd0);
   endtask

   // Advance the model with the inputs about to be sampled, then compare.
   task automatic tick();
      if (!rst_n) begin
         m8 = mreset();
         m5 = mreset();
      end else begin
         m8 = mstep(m8, 64'(req8), mode8, ack8, 8);
         m5 = mstep(m5, 64'(req5), mode5, ack5, 5);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int exp_seq[4];
      exp_seq = '{0, 4, 7, 0};
      m8 = mreset();
      m5 = mreset();
      rst_n = 1'b0;
      req8 = 8'hFF; mode8 = 1'b0; ack8 = 1'b0;
      req5 = 5'h1F; mode5 = 1'b0; ack5 = 1'b0;

      // Reset with every request asserted, then idle.
      tick();
      tick();
      chk("rst_valid", 64'(valid8), 64'd0);
      chk("rst_grant", 64'(grant8), 64'd0);
      rst_n = 1'b1;
      req8 = 8'h00; req5 = 5'h00;
      repeat (5) tick();
      chk("idle_valid", 64'(valid8), 64'd0);

      // Fixed priority, re-grant after one idle cycle.
      req8 = 8'hA4;
      tick();
      chk("fix_idx", 64'(idx8), 64'd7);
      chk("fix_grant", 64'(grant8), 64'h80);
      repeat (3) tick();
      ack8 = 1'b1;
      tick();
      chk("fix_ack_valid", 64'(valid8), 64'd0);
      ack8 = 1'b0;
      tick();
      chk("fix_regrant", 64'(idx8), 64'd7);
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0; req8 = 8'h00;
      tick();

      // Round-robin rotation over 8'h91.
      mode8 = 1'b1; req8 = 8'h91;
      for (int i = 0; i < 4; i++) begin
         ack8 = 1'b0;
         tick();
         chk("rr_seq", 64'(idx8), 64'(exp_seq[i]));
         ack8 = 1'b1;
         tick();
      end
      ack8 = 1'b0;
      tick();
      chk("rr_ptr1", 64'(idx8), 64'd4);
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0; req8 = 8'h00;
      tick();

      // Non-power-of-two wrap on the 5-input instance.
      mode5 = 1'b1; req5 = 5'b10001;
      tick();
      ack5 = 1'b1;
      tick();
      ack5 = 1'b0;
      tick();
      chk("wrap_idx4", 64'(idx5), 64'd4);
      ack5 = 1'b1;
      tick();
      ack5 = 1'b0;
      tick();
      chk("wrap_idx0", 64'(idx5), 64'd0);
      ack5 = 1'b1;
      tick();
      ack5 = 1'b0; req5 = 5'h00;
      tick();

      // Withdrawal vs ack: first move ptr to 2 via a grant of source 1.
      req8 = 8'h02;
      tick();
      ack8 = 1'b1; req8 = 8'h0D;
      tick();
      ack8 = 1'b0;
      tick();
      chk("wd_grant2", 64'(idx8), 64'd2);
      req8 = 8'h09;
      tick();
      chk("wd_drop", 64'(valid8), 64'd0);
      req8 = 8'h0D;
      tick();
      chk("wd_rewin2", 64'(idx8), 64'd2);
      req8 = 8'h09; ack8 = 1'b1;
      tick();
      chk("wd_ack_drop", 64'(valid8), 64'd0);
      req8 = 8'h0D; ack8 = 1'b0;
      tick();
      chk("wd_ptr3", 64'(idx8), 64'd3);
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0; req8 = 8'h00;
      tick();

      // Asynchronous reset in the middle of a grant.
      mode8 = 1'b0; req8 = 8'h20;
      tick();
      chk("mid_idx5", 64'(idx8), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      m8 = mreset();
      m5 = mreset();
      chk("async_valid", 64'(valid8), 64'd0);
      chk("async_grant", 64'(grant8), 64'd0);
      chk("async_idx", 64'(idx8), 64'd0);
      mode8 = 1'b1; req8 = 8'h30;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_idx", 64'(idx8), 64'd4);
      ack8 = 1'b1;
      tick();

      // Randomised traffic on both instances.
      for (int c = 0; c < 400; c++) begin
         req8 = 8'($urandom & $urandom);
         req5 = 5'($urandom & $urandom);
         if ($urandom_range(0, 7) == 0) mode8 = 1'($urandom);
         if ($urandom_range(0, 7) == 0) mode5 = 1'($urandom);
         ack8 = ($urandom_range(0, 2) == 0);
         ack5 = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
